// File: rtl/mio_pkg.sv
// Shared definitions for the LC-3 memory/IO sequencer: device map, status bits, FSM states.
// Optional feature macro: MIO_KBD_INT_EN (keyboard/display interrupt-enable bits and INT_REQ).
package mio_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CHAR_W = 8;

   localparam logic [DATA_W-1:0] KBSR_ADDR = 16'hFE00;
   localparam logic [DATA_W-1:0] KBDR_ADDR = 16'hFE02;
   localparam logic [DATA_W-1:0] DSR_ADDR  = 16'hFE04;
   localparam logic [DATA_W-1:0] DDR_ADDR  = 16'hFE06;

   localparam int unsigned RDY_BIT = 15;
   localparam int unsigned IE_BIT  = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEV  = 2'd1,
      ST_MEM  = 2'd2,
      ST_DONE = 2'd3
   } mio_state_t;

   typedef enum logic [1:0] {
      SEL_KBSR = 2'd0,
      SEL_KBDR = 2'd1,
      SEL_DSR  = 2'd2,
      SEL_DDR  = 2'd3
   } dev_sel_t;

   // True when the address hits one of the four device registers
   function automatic logic is_dev_addr(input logic [DATA_W-1:0] addr);
      return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
             (addr == DSR_ADDR)  || (addr == DDR_ADDR);
   endfunction

   // Device register select for a device address (KBSR for anything else)
   function automatic dev_sel_t addr_to_sel(input logic [DATA_W-1:0] addr);
      dev_sel_t sel;
      case (addr)
         KBDR_ADDR: sel = SEL_KBDR;
         DSR_ADDR:  sel = SEL_DSR;
         DDR_ADDR:  sel = SEL_DDR;
         default:   sel = SEL_KBSR;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mio_dev_regs.sv
// Keyboard (KBSR/KBDR) and display (DSR/DDR) registers with their device handshakes.
// Single-cycle access port; read data is combinational from the current register state.
// Optional feature macro: MIO_KBD_INT_EN (bit 14 interrupt enables and registered interrupt request).
module mio_dev_regs
   import mio_pkg::*;
(
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_acc,
   input  logic              i_we,
   input  dev_sel_t          i_sel,
   input  logic [CHAR_W-1:0] i_wdata,
`ifdef MIO_KBD_INT_EN
   input  logic              i_wie,
   output logic              o_int_req,
`endif
   output logic [DATA_W-1:0] o_rdata_c,
   input  logic              i_kb_valid,
   input  logic [CHAR_W-1:0] i_kb_data,
   output logic              o_kb_ovr,
   output logic              o_disp_valid,
   output logic [CHAR_W-1:0] o_disp_data,
   input  logic              i_disp_ack
);

   logic              r_kb_rdy;
   logic [CHAR_W-1:0] r_kbdr;
   logic              r_kb_ovr;
   logic              r_dsp_rdy;
   logic              r_disp_valid;
   logic [CHAR_W-1:0] r_disp_data;
   logic              w_kb_ie;
   logic              w_dsp_ie;
   logic              w_kbdr_rd;
   logic              w_ddr_wr;

   assign w_kbdr_rd = i_acc && !i_we && (i_sel == SEL_KBDR);
   assign w_ddr_wr  = i_acc &&  i_we && (i_sel == SEL_DDR);

   // Keyboard: latch a character when empty (or being read this edge), flag overrun otherwise
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_kb_rdy <= 1'b0;
         r_kbdr   <= '0;
         r_kb_ovr <= 1'b0;
      end else begin
         r_kb_ovr <= 1'b0;
         if (i_kb_valid) begin
            if (!r_kb_rdy || w_kbdr_rd) begin
               r_kbdr   <= i_kb_data;
               r_kb_rdy <= 1'b1;
            end else begin
               r_kb_ovr <= 1'b1;
            end
         end else if (w_kbdr_rd) begin
            r_kb_rdy <= 1'b0;
         end
      end
   end

   // Display: DDR write hands a character over when ready, ACK returns the ready flag
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_dsp_rdy    <= 1'b1;
         r_disp_valid <= 1'b0;
         r_disp_data  <= '0;
      end else begin
         if (r_disp_valid && i_disp_ack) begin
            r_disp_valid <= 1'b0;
            r_dsp_rdy    <= 1'b1;
         end
         if (w_ddr_wr && r_dsp_rdy) begin
            r_disp_data  <= i_wdata;
            r_disp_valid <= 1'b1;
            r_dsp_rdy    <= 1'b0;
         end
      end
   end

`ifdef MIO_KBD_INT_EN
   logic r_kb_ie;
   logic r_dsp_ie;
   logic r_int_req;

   // Interrupt enables are written through the status registers; request is registered
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_kb_ie   <= 1'b0;
         r_dsp_ie  <= 1'b0;
         r_int_req <= 1'b0;
      end else begin
         if (i_acc && i_we && (i_sel == SEL_KBSR)) r_kb_ie  <= i_wie;
         if (i_acc && i_we && (i_sel == SEL_DSR))  r_dsp_ie <= i_wie;
         r_int_req <= (r_kb_rdy && r_kb_ie) || (r_dsp_rdy && r_dsp_ie);
      end
   end

   assign w_kb_ie   = r_kb_ie;
   assign w_dsp_ie  = r_dsp_ie;
   assign o_int_req = r_int_req;
`else
   assign w_kb_ie  = 1'b0;
   assign w_dsp_ie = 1'b0;
`endif

   // Read mux over the current (pre-edge) register values
   always_comb begin
      o_rdata_c = '0;
      case (i_sel)
         SEL_KBSR: begin
            o_rdata_c[RDY_BIT] = r_kb_rdy;
            o_rdata_c[IE_BIT]  = w_kb_ie;
         end
         SEL_KBDR: o_rdata_c[CHAR_W-1:0] = r_kbdr;
         SEL_DSR: begin
            o_rdata_c[RDY_BIT] = r_dsp_rdy;
            o_rdata_c[IE_BIT]  = w_dsp_ie;
         end
         default: o_rdata_c = '0;
      endcase
   end

   assign o_kb_ovr     = r_kb_ovr;
   assign o_disp_valid = r_disp_valid;
   assign o_disp_data  = r_disp_data;

endmodule

// File: rtl/mio_ctrl.sv
// LC-3 memory/IO access sequencer: decodes MAR, runs the RAM handshake with timeout,
// and fronts the keyboard/display registers. R pulses for one cycle per completed access.
// Optional feature macro: MIO_KBD_INT_EN (adds INT_REQ output and writable bit-14 enables).
module mio_ctrl
   import mio_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255
)(
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              MIO_EN,
   input  logic              R_W,
   input  logic [DATA_W-1:0] MAR_OUT,
   input  logic [DATA_W-1:0] MDR_OUT,
   output logic [DATA_W-1:0] MIO_DATA,
   output logic              R,
   output logic              MEM_ERR,
   output logic              MEM_REQ,
   output logic              MEM_WE,
   output logic [DATA_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   input  logic [DATA_W-1:0] MEM_RDATA,
   input  logic              MEM_RDY,
   input  logic              KB_VALID,
   input  logic [CHAR_W-1:0] KB_DATA,
   output logic              KB_OVR,
   output logic              DISP_VALID,
   output logic [CHAR_W-1:0] DISP_DATA,
`ifdef MIO_KBD_INT_EN
   output logic              INT_REQ,
`endif
   input  logic              DISP_ACK
);

   localparam int unsigned TMO_W    = $clog2(MEM_TIMEOUT + 2);
   localparam int unsigned TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

   mio_state_t        r_state;
   logic              r_we;
   dev_sel_t          r_sel;
   logic [CHAR_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_mio_data;
   logic              r_r;
   logic              r_mem_err;
   logic              r_mem_req;
   logic              r_mem_we;
   logic [DATA_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [TMO_W-1:0]  r_tmo_cnt;
   logic              w_dev_acc;
   logic              w_tmo_hit;
   logic [DATA_W-1:0] w_dev_rdata;

   assign w_dev_acc = (r_state == ST_DEV);
   assign w_tmo_hit = (MEM_TIMEOUT != 0) && (r_tmo_cnt == TMO_W'(TMO_LAST));

`ifdef MIO_KBD_INT_EN
   logic r_wie;
   logic w_int_req;

   // Interrupt-enable write bit travels with the latched request
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n)                     r_wie <= 1'b0;
      else if (r_state == ST_IDLE && MIO_EN) r_wie <= MDR_OUT[IE_BIT];
   end

   assign INT_REQ = w_int_req;
`endif

   // Access sequencer: IDLE -> DEV/MEM -> DONE (R pulse) -> IDLE
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_state     <= ST_IDLE;
         r_we        <= 1'b0;
         r_sel       <= SEL_KBSR;
         r_wdata     <= '0;
         r_mio_data  <= '0;
         r_r         <= 1'b0;
         r_mem_err   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_tmo_cnt   <= '0;
      end else begin
         r_r       <= 1'b0;
         r_mem_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (MIO_EN) begin
                  r_we    <= R_W;
                  r_sel   <= addr_to_sel(MAR_OUT);
                  r_wdata <= MDR_OUT[CHAR_W-1:0];
                  if (is_dev_addr(MAR_OUT)) begin
                     r_state <= ST_DEV;
                  end else begin
                     r_state     <= ST_MEM;
                     r_mem_req   <= 1'b1;
                     r_mem_we    <= R_W;
                     r_mem_addr  <= MAR_OUT;
                     r_mem_wdata <= MDR_OUT;
                     r_tmo_cnt   <= '0;
                  end
               end
            end
            ST_DEV: begin
               r_mio_data <= r_we ? '0 : w_dev_rdata;
               r_r        <= 1'b1;
               r_state    <= ST_DONE;
            end
            ST_MEM: begin
               if (MEM_RDY) begin
                  r_mem_req  <= 1'b0;
                  r_mio_data <= r_mem_we ? '0 : MEM_RDATA;
                  r_r        <= 1'b1;
                  r_state    <= ST_DONE;
               end else if (w_tmo_hit) begin
                  r_mem_req  <= 1'b0;
                  r_mio_data <= '0;
                  r_mem_err  <= 1'b1;
                  r_r        <= 1'b1;
                  r_state    <= ST_DONE;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   mio_dev_regs u_dev_regs (
      .i_Clk        (i_Clk),
      .i_Rst_n      (i_Rst_n),
      .i_acc        (w_dev_acc),
      .i_we         (r_we),
      .i_sel        (r_sel),
      .i_wdata      (r_wdata),
`ifdef MIO_KBD_INT_EN
      .i_wie        (r_wie),
      .o_int_req    (w_int_req),
`endif
      .o_rdata_c    (w_dev_rdata),
      .i_kb_valid   (KB_VALID),
      .i_kb_data    (KB_DATA),
      .o_kb_ovr     (KB_OVR),
      .o_disp_valid (DISP_VALID),
      .o_disp_data  (DISP_DATA),
      .i_disp_ack   (DISP_ACK)
   );

   assign MIO_DATA  = r_mio_data;
   assign R         = r_r;
   assign MEM_ERR   = r_mem_err;
   assign MEM_REQ   = r_mem_req;
   assign MEM_WE    = r_mem_we;
   assign MEM_ADDR  = r_mem_addr;
   assign MEM_WDATA = r_mem_wdata;

endmodule

// File: doc/mio_ctrl.md
Name: mio_ctrl

Overview:
- Memory/IO access sequencer for the LC-3 datapath; sits between the control FSM (MIO_EN, R_W), MAR/MDR, external memory and the keyboard/display devices.
- Decodes MAR into RAM or device registers KBSR/KBDR/DSR/DDR and runs the multi-cycle RAM handshake.
- Returns read data to MIOMUX and signals completion with R.
- Owns the device status/data registers and their handshakes with bounded, synthesizable logic.

Parameters:
- MEM_TIMEOUT, 255, max cycles waiting for MEM_RDY before forced completion; 0 disables the timeout.

Ports:
- i_Clk  in  1  system clock, all state on rising edge
- i_Rst_n  in  1  asynchronous active-low reset
- MIO_EN  in  1  access request from control FSM, held until R seen
- R_W  in  1  1=write, 0=read; sampled with MIO_EN
- MAR_OUT  in  16  access address
- MDR_OUT  in  16  write data
- MIO_DATA  out  16  read data to MIOMUX, valid while R=1
- R  out  1  access complete, one-cycle pulse
- MEM_ERR  out  1  one-cycle pulse with R when the RAM access timed out
- MEM_REQ  out  1  RAM request, held until MEM_RDY
- MEM_WE  out  1  RAM write enable, valid with MEM_REQ
- MEM_ADDR  out  16  RAM address, valid with MEM_REQ
- MEM_WDATA  out  16  RAM write data
- MEM_RDATA  in  16  RAM read data, valid with MEM_RDY
- MEM_RDY  in  1  RAM done
- KB_VALID  in  1  one-cycle keyboard character strobe
- KB_DATA  in  8  keyboard character
- KB_OVR  out  1  one-cycle pulse when a character is dropped
- DISP_VALID  out  1  display character pending
- DISP_DATA  out  8  character to display
- DISP_ACK  in  1  display consumed the character

Behaviour:
- Reset values: state IDLE; MIO_DATA=0, R=0, MEM_ERR=0, MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, KB_OVR=0, DISP_VALID=0, DISP_DATA=0; KBSR=0, KBDR=0, DSR=16'h8000 (display ready).
- Reset is asynchronous at any point. A reset during MEM aborts the access and drops MEM_REQ immediately. No R is issued for the aborted access.
- Address map: FE00 KBSR, FE02 KBDR, FE04 DSR, FE06 DDR. Every other address goes to RAM.
- FSM states: IDLE, DEV, MEM, DONE.
- IDLE:
  - MIO_EN=1 latches address, R_W and data.
  - Next state is DEV for a device address, otherwise MEM.
- DEV:
  - Performs the register read or write in one cycle. Next state DONE.
  - Device latency: R high in the 2nd cycle after MIO_EN is sampled.
- MEM:
  - MEM_REQ=1 with MEM_WE, MEM_ADDR and MEM_WDATA stable.
  - On the edge with MEM_RDY=1: capture MEM_RDATA (reads), drop MEM_REQ, go to DONE.
  - The timeout counter counts cycles spent in MEM. When it reaches MEM_TIMEOUT: go to DONE, MIO_DATA=0, MEM_ERR pulses with R.
- DONE:
  - R=1 for exactly one cycle, then IDLE.
  - If MIO_EN is still high in IDLE, a new access starts. The FSM must drop MIO_EN on R.
- Device reads:
  - KBSR returns {rdy,ie,14'b0}.
  - KBDR returns {8'b0,char} and clears KBSR[15] on the DEV edge.
  - DSR returns {rdy,ie,14'b0}.
  - DDR returns 0.
- Device writes:
  - KBSR/DSR: only bit 14 is writable, and only with the optional feature. Bit 15 is read-only.
  - KBDR: write ignored.
  - DDR: if DSR[15]=1, DISP_DATA=MDR_OUT[7:0], DISP_VALID=1, DSR[15]=0. If DSR[15]=0, the write is dropped and DISP_VALID/DISP_DATA are unchanged.
- Display handshake: DISP_VALID holds until the edge with DISP_ACK=1; then DISP_VALID=0 and DSR[15]=1. DISP_ACK while DISP_VALID=0 is ignored.
- Keyboard:
  - KB_VALID with KBSR[15]=0 latches KBDR and sets KBSR[15].
  - KB_VALID with KBSR[15]=1 drops the character and pulses KB_OVR.
  - KB_VALID on the same edge as a KBDR-read clear: the read returns the old char, the new char is latched, KBSR[15] stays 1, no KB_OVR.

Optional Feature:
- Macro MIO_KBD_INT_EN.
- Defined:
  - KBSR[14] and DSR[14] are writable interrupt-enable bits (reset 0).
  - Extra output INT_REQ = (KBSR[15]&KBSR[14]) | (DSR[15]&DSR[14]), registered, 1-cycle latency.
- Undefined: bit 14 reads 0, writes to it are ignored, and there is no INT_REQ port.

Decomposition:
- Package mio_pkg:
  - Device address constants KBSR_ADDR, KBDR_ADDR, DSR_ADDR, DDR_ADDR.
  - Status bit indices RDY_BIT=15, IE_BIT=14.
  - FSM state enum.
- One natural sub-module, mio_dev_regs: KBSR/KBDR/DSR keyboard and display handshakes, single-cycle read/write port. The top keeps the FSM, decode and RAM path.

Test Plan:
- Read RAM x3000, MEM_RDY after 3 cycles with MEM_RDATA=x1234 -> MEM_REQ high 3 cycles, MIO_DATA=x1234 with one R pulse, MEM_ERR=0.
- KB_VALID KB_DATA=x41, then read FE00 and FE02, then FE00 -> x8000, x0041, x0000.
- Write FE06 data x0058 -> DISP_VALID=1, DISP_DATA=x58, DSR reads x0000. DISP_ACK -> DSR reads x8000. Second FE06 write before ACK -> dropped, DISP_DATA stays x58.
- Two KB_VALID (x41, x42) with no read -> KB_OVR pulses on x42, KBDR reads x0041.
- MEM_TIMEOUT=4, MEM_RDY never asserted -> R and MEM_ERR in the same cycle, MIO_DATA=0. Reset asserted mid-MEM -> MEM_REQ=0 immediately, no R.
- MIO_KBD_INT_EN: write FE00 x4000, then KB_VALID -> INT_REQ=1. Read FE02 -> INT_REQ=0.
